// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: shares one Wishbone master port between instruction fetch and data access.
// Optional bus watchdog is enabled by defining ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  output logic                stallreq_from_if,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ack_o,
  output logic                stallreq_from_mem,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_sel_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_dat_o,
  input  logic [DATA_W-1:0]   m_dat_i,
  input  logic                m_ack_i,
  output logic                bus_err_o
);
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_BUS  = 3'd1,
    MEM_BUS = 3'd2,
    DRAIN   = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t              state_r, next_s;
  logic                owner_mem_r, owner_mem_d;
  logic                cyc_r, cyc_d;
  logic                we_r, we_d;
  logic [SEL_W-1:0]    sel_r, sel_d;
  logic [ADDR_W-1:0]   addr_r, addr_d;
  logic [DATA_W-1:0]   dat_r, dat_d;
  logic                if_ack_r, if_ack_d;
  logic                mem_ack_r, mem_ack_d;
  logic [DATA_W-1:0]   if_rdata_r, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_r, mem_rdata_d;
  logic                err_r, err_d;
  logic                timeout_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_r;
  logic             counting_s;

  assign counting_s = (state_r == IF_BUS) || (state_r == MEM_BUS) || (state_r == DRAIN);
  assign timeout_s  = counting_s && (cnt_r == CNT_W'(TIMEOUT - 1)) && !m_ack_i;

  // Watchdog counter: restarts on every state change, runs only while a bus cycle is open
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (!counting_s || (next_s != state_r)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 32'sd0);
  assign timeout_s        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; MEM wins over IF, a flushed cycle is drained rather than abandoned
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush_i)        next_s = IDLE;
        else if (mem_req_i) next_s = MEM_BUS;
        else if (if_req_i)  next_s = IF_BUS;
        else                next_s = IDLE;
      end
      IF_BUS, MEM_BUS: begin
        if (m_ack_i && !flush_i) next_s = RESP;
        else if (m_ack_i)        next_s = IDLE;
        else if (flush_i)        next_s = DRAIN;
        else if (timeout_s)      next_s = RESP;
        else                     next_s = state_r;
      end
      DRAIN: begin
        if (m_ack_i || timeout_s) next_s = IDLE;
        else                      next_s = DRAIN;
      end
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Next values of the registered bus and requester outputs
  always_comb begin
    owner_mem_d = owner_mem_r;
    cyc_d       = cyc_r;
    we_d        = we_r;
    sel_d       = sel_r;
    addr_d      = addr_r;
    dat_d       = dat_r;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_r;
    mem_rdata_d = mem_rdata_r;
    err_d       = 1'b0;
    case (state_r)
      IDLE: begin
        if (next_s == MEM_BUS) begin
          owner_mem_d = 1'b1;
          cyc_d       = 1'b1;
          we_d        = mem_we_i;
          sel_d       = mem_sel_i;
          addr_d      = mem_addr_i;
          dat_d       = mem_wdata_i;
        end else if (next_s == IF_BUS) begin
          owner_mem_d = 1'b0;
          cyc_d       = 1'b1;
          we_d        = 1'b0;
          sel_d       = {SEL_W{1'b1}};
          addr_d      = if_addr_i;
          dat_d       = '0;
        end else begin
          cyc_d = 1'b0;
        end
      end
      IF_BUS, MEM_BUS: begin
        if (next_s == RESP) begin
          // Timeout completions return zero data with the error flag
          cyc_d = 1'b0;
          err_d = timeout_s;
          if (owner_mem_r) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = (m_ack_i && !we_r) ? m_dat_i : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = m_ack_i ? m_dat_i : '0;
          end
        end else if (next_s == IDLE) begin
          cyc_d = 1'b0;
        end else begin
          cyc_d = 1'b1;
        end
      end
      DRAIN:   cyc_d = (next_s == DRAIN);
      RESP:    cyc_d = 1'b0;
      default: cyc_d = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_mem_r <= 1'b0;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= '0;
      addr_r      <= '0;
      dat_r       <= '0;
      if_ack_r    <= 1'b0;
      mem_ack_r   <= 1'b0;
      if_rdata_r  <= '0;
      mem_rdata_r <= '0;
      err_r       <= 1'b0;
    end else begin
      owner_mem_r <= owner_mem_d;
      cyc_r       <= cyc_d;
      we_r        <= we_d;
      sel_r       <= sel_d;
      addr_r      <= addr_d;
      dat_r       <= dat_d;
      if_ack_r    <= if_ack_d;
      mem_ack_r   <= mem_ack_d;
      if_rdata_r  <= if_rdata_d;
      mem_rdata_r <= mem_rdata_d;
      err_r       <= err_d;
    end
  end

  assign m_cyc_o           = cyc_r;
  assign m_stb_o           = cyc_r;
  assign m_we_o            = we_r;
  assign m_sel_o           = sel_r;
  assign m_addr_o          = addr_r;
  assign m_dat_o           = dat_r;
  assign if_ack_o          = if_ack_r;
  assign mem_ack_o         = mem_ack_r;
  assign if_rdata_o        = if_rdata_r;
  assign mem_rdata_o       = mem_rdata_r;
  assign bus_err_o         = err_r;
  assign stallreq_from_if  = if_req_i & ~if_ack_r;
  assign stallreq_from_mem = mem_req_i & ~mem_ack_r;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed, table-driven bench for wb_bus_arbiter with hand-written flush, reset and timeout sequences.
module tb_wb_bus_arbiter;
  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        stall_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_mem;
  logic        m_cyc;
  logic        m_stb;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic        m_ack;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .stallreq_from_if(stall_if),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
    .stallreq_from_mem(stall_mem),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel), .m_addr_o(m_addr),
    .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack), .bus_err_o(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        flush, if_req;
    logic [31:0] if_addr;
    logic        mem_req, mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata;
    logic        ack;
    logic [31:0] dat;
    logic        e_cyc, e_we;
    logic [31:0] e_addr, e_dat;
    logic        e_if_ack;
    logic [31:0] e_if_rdata;
    logic        e_mem_ack;
    logic [31:0] e_mem_rdata;
    logic        e_st_if, e_st_mem;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic fl, input logic ir, input logic [31:0] ia,
    input logic mr, input logic mw, input logic [3:0] ms, input logic [31:0] ma, input logic [31:0] md,
    input logic ak, input logic [31:0] dt,
    input logic ec, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
    input logic eia, input logic [31:0] eir, input logic ema, input logic [31:0] emr,
    input logic esi, input logic esm);
    vec_t v;
    v.flush = fl; v.if_req = ir; v.if_addr = ia;
    v.mem_req = mr; v.mem_we = mw; v.mem_sel = ms; v.mem_addr = ma; v.mem_wdata = md;
    v.ack = ak; v.dat = dt;
    v.e_cyc = ec; v.e_we = ew; v.e_addr = ea; v.e_dat = ed;
    v.e_if_ack = eia; v.e_if_rdata = eir; v.e_mem_ack = ema; v.e_mem_rdata = emr;
    v.e_st_if = esi; v.e_st_mem = esm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    m_ack = 1'b0; m_dat_i = 32'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, {31'd0, m_cyc}, 32'd0);
    chk({tag, "_stb"}, {31'd0, m_stb}, 32'd0);
    chk({tag, "_we"}, {31'd0, m_we}, 32'd0);
    chk({tag, "_sel"}, {28'd0, m_sel}, 32'd0);
    chk({tag, "_addr"}, m_addr, 32'd0);
    chk({tag, "_mdat"}, m_dat_o, 32'd0);
    chk({tag, "_if_ack"}, {31'd0, if_ack}, 32'd0);
    chk({tag, "_mem_ack"}, {31'd0, mem_ack}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    chk({tag, "_err"}, {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    chk("reset_stall_if", {31'd0, stall_if}, 32'd0);
    chk("reset_stall_mem", {31'd0, stall_mem}, 32'd0);
    #4 rst = 1'b1;
    step();

    // IF read, MEM write vs IF, MEM read held across two accesses, flush in IDLE
    vecs.push_back(mk(0,1,32'h100, 0,0,4'h0,32'h0,32'h0, 0,32'h0,          1,0,32'h100,32'h0, 0,32'h0,0,32'h0,1,0));
    vecs.push_back(mk(0,1,32'h100, 0,0,4'h0,32'h0,32'h0, 0,32'h0,          1,0,32'h100,32'h0, 0,32'h0,0,32'h0,1,0));
    vecs.push_back(mk(0,1,32'h100, 0,0,4'h0,32'h0,32'h0, 0,32'h0,          1,0,32'h100,32'h0, 0,32'h0,0,32'h0,1,0));
    vecs.push_back(mk(0,1,32'h100, 0,0,4'h0,32'h0,32'h0, 1,32'hDEADBEEF,   0,0,32'h0,32'h0, 1,32'hDEADBEEF,0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,   0,0,4'h0,32'h0,32'h0, 0,32'h0,          0,0,32'h0,32'h0, 0,32'hDEADBEEF,0,32'h0,0,0));
    vecs.push_back(mk(0,1,32'h200, 1,1,4'hF,32'h1000,32'h12345678, 0,32'h0,        1,1,32'h1000,32'h12345678, 0,32'hDEADBEEF,0,32'h0,1,1));
    vecs.push_back(mk(0,1,32'h200, 1,1,4'hF,32'h1000,32'h12345678, 1,32'hAAAA5555, 0,0,32'h0,32'h0, 0,32'hDEADBEEF,1,32'h0,1,0));
    vecs.push_back(mk(0,1,32'h200, 0,0,4'h0,32'h0,32'h0, 0,32'h0,          0,0,32'h0,32'h0, 0,32'hDEADBEEF,0,32'h0,1,0));
    vecs.push_back(mk(0,1,32'h200, 0,0,4'h0,32'h0,32'h0, 0,32'h0,          1,0,32'h200,32'h0, 0,32'hDEADBEEF,0,32'h0,1,0));
    vecs.push_back(mk(0,1,32'h200, 0,0,4'h0,32'h0,32'h0, 1,32'h0BADF00D,   0,0,32'h0,32'h0, 1,32'h0BADF00D,0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,   0,0,4'h0,32'h0,32'h0, 0,32'h0,          0,0,32'h0,32'h0, 0,32'h0BADF00D,0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,   1,0,4'hF,32'h10,32'h0, 0,32'h0,         1,0,32'h10,32'h0, 0,32'h0BADF00D,0,32'h0,0,1));
    vecs.push_back(mk(0,0,32'h0,   1,0,4'hF,32'h10,32'h0, 1,32'h11111111,  0,0,32'h0,32'h0, 0,32'h0BADF00D,1,32'h11111111,0,0));
    vecs.push_back(mk(0,0,32'h0,   1,0,4'hF,32'h14,32'h0, 0,32'h0,         0,0,32'h0,32'h0, 0,32'h0BADF00D,0,32'h11111111,0,1));
    vecs.push_back(mk(0,0,32'h0,   1,0,4'hF,32'h14,32'h0, 0,32'h0,         1,0,32'h14,32'h0, 0,32'h0BADF00D,0,32'h11111111,0,1));
    vecs.push_back(mk(0,0,32'h0,   1,0,4'hF,32'h14,32'h0, 1,32'h22222222,  0,0,32'h0,32'h0, 0,32'h0BADF00D,1,32'h22222222,0,0));
    vecs.push_back(mk(0,0,32'h0,   0,0,4'h0,32'h0,32'h0, 0,32'h0,          0,0,32'h0,32'h0, 0,32'h0BADF00D,0,32'h22222222,0,0));
    vecs.push_back(mk(1,1,32'h300, 0,0,4'h0,32'h0,32'h0, 0,32'h0,          0,0,32'h0,32'h0, 0,32'h0BADF00D,0,32'h22222222,1,0));
    vecs.push_back(mk(0,1,32'h300, 0,0,4'h0,32'h0,32'h0, 0,32'h0,          1,0,32'h300,32'h0, 0,32'h0BADF00D,0,32'h22222222,1,0));
    vecs.push_back(mk(0,1,32'h300, 0,0,4'h0,32'h0,32'h0, 1,32'h33333333,   0,0,32'h0,32'h0, 1,32'h33333333,0,32'h22222222,0,0));
    vecs.push_back(mk(0,0,32'h0,   0,0,4'h0,32'h0,32'h0, 0,32'h0,          0,0,32'h0,32'h0, 0,32'h33333333,0,32'h22222222,0,0));

    foreach (vecs[i]) begin
      flush = vecs[i].flush; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      mem_req = vecs[i].mem_req; mem_we = vecs[i].mem_we; mem_sel = vecs[i].mem_sel;
      mem_addr = vecs[i].mem_addr; mem_wdata = vecs[i].mem_wdata;
      m_ack = vecs[i].ack; m_dat_i = vecs[i].dat;
      step();
      chk($sformatf("v%0d_cyc", i), {31'd0, m_cyc}, {31'd0, vecs[i].e_cyc});
      chk($sformatf("v%0d_stb", i), {31'd0, m_stb}, {31'd0, vecs[i].e_cyc});
      if (vecs[i].e_cyc) begin
        chk($sformatf("v%0d_we", i), {31'd0, m_we}, {31'd0, vecs[i].e_we});
        chk($sformatf("v%0d_sel", i), {28'd0, m_sel}, 32'hF);
        chk($sformatf("v%0d_addr", i), m_addr, vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("v%0d_mdat", i), m_dat_o, vecs[i].e_dat);
      end
      chk($sformatf("v%0d_if_ack", i), {31'd0, if_ack}, {31'd0, vecs[i].e_if_ack});
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("v%0d_mem_ack", i), {31'd0, mem_ack}, {31'd0, vecs[i].e_mem_ack});
      chk($sformatf("v%0d_mem_rdata", i), mem_rdata, vecs[i].e_mem_rdata);
      chk($sformatf("v%0d_stall_if", i), {31'd0, stall_if}, {31'd0, vecs[i].e_st_if});
      chk($sformatf("v%0d_stall_mem", i), {31'd0, stall_mem}, {31'd0, vecs[i].e_st_mem});
      chk($sformatf("v%0d_err", i), {31'd0, bus_err}, 32'd0);
    end

    // Flush one cycle after stb: cycle held until the slave acks, then silently dropped
    drive_idle();
    if_req = 1'b1; if_addr = 32'h400;
    step();
    chk("fl_cyc_open", {31'd0, m_cyc}, 32'd1);
    flush = 1'b1; if_req = 1'b0;
    step();
    chk("fl_drain_cyc", {31'd0, m_cyc}, 32'd1);
    chk("fl_drain_ack", {31'd0, if_ack}, 32'd0);
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("fl_wait%0d_cyc", k), {31'd0, m_cyc}, 32'd1);
      chk($sformatf("fl_wait%0d_ack", k), {31'd0, if_ack}, 32'd0);
    end
    m_ack = 1'b1; m_dat_i = 32'h55555555;
    step();
    chk("fl_end_cyc", {31'd0, m_cyc}, 32'd0);
    chk("fl_end_ack", {31'd0, if_ack}, 32'd0);
    chk("fl_end_rdata", if_rdata, 32'h33333333);
    m_ack = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    step();
    chk("fl_regrant_cyc", {31'd0, m_cyc}, 32'd1);
    chk("fl_regrant_addr", m_addr, 32'h500);
    chk("fl_regrant_ack", {31'd0, if_ack}, 32'd0);
    m_ack = 1'b1; m_dat_i = 32'h77777777;
    step();
    chk("fl_regrant_done_ack", {31'd0, if_ack}, 32'd1);
    chk("fl_regrant_done_rdata", if_rdata, 32'h77777777);
    m_ack = 1'b0; if_req = 1'b0;
    step();

    // Flush coincident with slave ack: straight back to IDLE, no ack, data kept
    if_req = 1'b1; if_addr = 32'h600;
    step();
    chk("flack_cyc_open", {31'd0, m_cyc}, 32'd1);
    flush = 1'b1; m_ack = 1'b1; m_dat_i = 32'h88888888; if_req = 1'b0;
    step();
    chk("flack_cyc", {31'd0, m_cyc}, 32'd0);
    chk("flack_ack", {31'd0, if_ack}, 32'd0);
    chk("flack_rdata", if_rdata, 32'h77777777);
    flush = 1'b0; m_ack = 1'b0;
    step();
    chk("flack_after_ack", {31'd0, if_ack}, 32'd0);

    // Asynchronous reset in the middle of a MEM transaction
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h20;
    step();
    chk("rst_pre_cyc", {31'd0, m_cyc}, 32'd1);
    #3 rst = 1'b0; mem_req = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    chk("rst_mid_stall_mem", {31'd0, stall_mem}, 32'd0);
    chk("rst_mid_stall_if", {31'd0, stall_if}, 32'd0);
    step();
    #4 rst = 1'b1;
    step();
    mem_req = 1'b1; mem_addr = 32'h24;
    step();
    chk("rst_after_cyc", {31'd0, m_cyc}, 32'd1);
    chk("rst_after_addr", m_addr, 32'h24);
    m_ack = 1'b1; m_dat_i = 32'h66666666;
    step();
    chk("rst_after_ack", {31'd0, mem_ack}, 32'd1);
    chk("rst_after_rdata", mem_rdata, 32'h66666666);
    m_ack = 1'b0; mem_req = 1'b0;
    step();

`ifdef ARB_TIMEOUT_EN
    // Slave never acks: watchdog closes the cycle after 8 bus cycles
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h30;
    step();
    chk("to_cyc_open", {31'd0, m_cyc}, 32'd1);
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("to_hold%0d_cyc", k), {31'd0, m_cyc}, 32'd1);
      chk($sformatf("to_hold%0d_ack", k), {31'd0, mem_ack}, 32'd0);
    end
    step();
    chk("to_cyc", {31'd0, m_cyc}, 32'd0);
    chk("to_ack", {31'd0, mem_ack}, 32'd1);
    chk("to_err", {31'd0, bus_err}, 32'd1);
    chk("to_rdata", mem_rdata, 32'h0);
    mem_req = 1'b0;
    step();
    chk("to_ack_clear", {31'd0, mem_ack}, 32'd0);
    chk("to_err_clear", {31'd0, bus_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
